// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// State encoding, MMIO address and latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
  localparam int          LAT_W     = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with byte-lane writes.
// Synchronous write, combinational read, no reset.
module dmem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: memory-side responder for the pipeline load/store path.
// Optional MMIO output register enabled by DMEM_MMIO_EN.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic [31:0] mmio_q
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

  state_t state, state_nx;
  logic [LAT_W-1:0] cnt;

  logic accept, misal, oor, is_mmio, bad;
  logic ram_we;
  logic [IW-1:0] idx_q, cur_idx;
  logic we_q, err_q, cur_we, cur_err, cur_mmio;
  logic [31:0] ram_rdata, load_data;

  assign accept = req_valid & req_ready;
  assign misal  = req_addr[1:0] != 2'b00;

`ifdef DMEM_MMIO_EN
  logic mmio_sel_q;
  assign is_mmio = req_addr == MMIO_ADDR;
`else
  assign is_mmio = 1'b0;
`endif

  assign oor = (req_addr >= LIMIT) & ~is_mmio;
  assign bad = misal | oor;

  assign ram_we = accept & req_we & ~bad & ~is_mmio & ~reset;

  // In IDLE the live request is the one in flight (LATENCY=1 answers
  // at the accept edge); afterwards the latched copy is used.
  assign cur_idx = (state == IDLE) ? req_addr[IW+1:2] : idx_q;
  assign cur_we  = (state == IDLE) ? req_we : we_q;
  assign cur_err = (state == IDLE) ? bad : err_q;

`ifdef DMEM_MMIO_EN
  assign cur_mmio  = (state == IDLE) ? is_mmio : mmio_sel_q;
  assign load_data = cur_mmio ? mmio_q : ram_rdata;
`else
  assign cur_mmio  = 1'b0;
  assign load_data = ram_rdata;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .be   (req_be),
    .waddr(req_addr[IW+1:2]),
    .wdata(req_wdata),
    .raddr(cur_idx),
    .rdata(ram_rdata)
  );

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && accept) cnt <= CNT_INIT;
      else if (state == WAIT)      cnt <= cnt - 1'b1;
    end
  end

  // Capture the accepted request so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= req_addr[IW+1:2];
      we_q  <= req_we;
      err_q <= bad;
`ifdef DMEM_MMIO_EN
      mmio_sel_q <= is_mmio;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == LAT_W'(1)) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Response data/error are loaded entering RESP and zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state_nx == RESP) begin
      rsp_err   <= cur_err;
      rsp_rdata <= (cur_we | cur_err) ? 32'h0 : load_data;
    end else begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

`ifdef DMEM_MMIO_EN
  // MMIO register: byte-lane store at the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_q <= '0;
    end else if (accept & req_we & is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mmio_q[8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end
`else
  assign mmio_q = 32'h0;
`endif

  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign stall     = ((state == IDLE) & req_valid) | (state == WAIT);

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed bench for dmem_resp at LATENCY 2, 1 and 4.
// Expectations for address 0xFFFF_FFF0 follow DMEM_MMIO_EN.
module tb_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string t, input logic [63:0] o,
                     input logic [63:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", t, o, e);
    end
  endtask

  logic        rst [3];
  logic        v   [3];
  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        er  [3];
  logic        st  [3];
  logic [31:0] mm  [3];

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [1:0]  sel;

  logic        o_ready, o_rv, o_err, o_stall;
  logic [31:0] o_rdata;

  assign v[0] = req_valid & (sel == 2'd0);
  assign v[1] = req_valid & (sel == 2'd1);
  assign v[2] = req_valid & (sel == 2'd2);

  assign o_ready = rdy[sel];
  assign o_rv    = rv[sel];
  assign o_rdata = rd[sel];
  assign o_err   = er[sel];
  assign o_stall = st[sel];

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
    .clk(clk), .reset(rst[0]), .req_valid(v[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .rsp_err(er[0]), .stall(st[0]), .mmio_q(mm[0])
  );

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) u_b (
    .clk(clk), .reset(rst[1]), .req_valid(v[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .rsp_err(er[1]), .stall(st[1]), .mmio_q(mm[1])
  );

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(4)) u_c (
    .clk(clk), .reset(rst[2]), .req_valid(v[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
    .rsp_err(er[2]), .stall(st[2]), .mmio_q(mm[2])
  );

  task automatic xfer(input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input int explat, input string tag,
                      output logic [31:0] rdata, output logic err);
    int   lat;
    logic ok;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_be = be;
    req_valid = 1'b1;
    #1;
    chk({tag, " ready"}, o_ready, 1'b1);
    chk({tag, " stall_acc"}, o_stall, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = ~we; req_addr = 32'h8; req_wdata = 32'h5A5A_5A5A;
    req_be = 4'hF;
    lat = 1;
    ok  = 1'b1;
    while (o_rv !== 1'b1 && lat < 20) begin
      if (o_stall !== 1'b1 || o_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, explat);
    chk({tag, " wait_stall"}, ok, 1'b1);
    chk({tag, " resp_stall"}, o_stall, 1'b0);
    chk({tag, " resp_ready"}, o_ready, 1'b0);
    rdata = o_rdata;
    err   = o_err;
    @(negedge clk);
    chk({tag, " idle_out"}, {o_rv, o_err, o_rdata}, 34'h0);
  endtask

  logic [31:0] r;
  logic        e;
  int          acc, cnt;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; sel = 2'd0;
    rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst ready", o_ready, 1'b1);
    chk("rst rsp_valid", o_rv, 1'b0);
    chk("rst rdata", o_rdata, 32'h0);
    chk("rst err", o_err, 1'b0);
    chk("rst stall", o_stall, 1'b0);
    chk("rst mmio", mm[0], 32'h0);
    rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;

    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, "st10", r, e);
    chk("st10 rdata", r, 32'h0);
    chk("st10 err", e, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 2, "ld10", r, e);
    chk("ld10 rdata", r, 32'hDEAD_BEEF);
    chk("ld10 err", e, 1'b0);

    xfer(1'b1, 32'h20, 32'h1122_3344, 4'hF, 2, "st20", r, e);
    xfer(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 2, "st20be", r, e);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 2, "ld20", r, e);
    chk("ld20 rdata", r, 32'h11BB_33DD);

    xfer(1'b0, 32'h13, 32'h0, 4'hF, 2, "ld13", r, e);
    chk("ld13 err", e, 1'b1);
    chk("ld13 rdata", r, 32'h0);

    xfer(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 2, "st0", r, e);
    xfer(1'b1, 32'h400, 32'hBAD0_BAD0, 4'hF, 2, "st400", r, e);
    chk("st400 err", e, 1'b1);
    chk("st400 rdata", r, 32'h0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 2, "ld0", r, e);
    chk("ld0 rdata", r, 32'hCAFE_F00D);
    chk("ld0 err", e, 1'b0);

    xfer(1'b1, 32'h10, 32'h0, 4'h0, 2, "stbe0", r, e);
    chk("stbe0 err", e, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 2, "ld10b", r, e);
    chk("ld10b rdata", r, 32'hDEAD_BEEF);

    xfer(1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 4'h3, 2, "stmm", r, e);
`ifdef DMEM_MMIO_EN
    chk("stmm err", e, 1'b0);
    chk("stmm mmio", mm[0], 32'h0000_5678);
    xfer(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, 2, "ldmm", r, e);
    chk("ldmm rdata", r, 32'h0000_5678);
    chk("ldmm err", e, 1'b0);
`else
    chk("stmm err", e, 1'b1);
    chk("stmm mmio", mm[0], 32'h0);
`endif

    sel = 2'd1;
    xfer(1'b1, 32'h8, 32'h0102_0304, 4'hF, 1, "l1st", r, e);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, 1, "l1ld", r, e);
    chk("l1ld rdata", r, 32'h0102_0304);

    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h8; req_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("b2b rsp_valid", o_rv, (k % 2 == 1));
      chk("b2b ready", o_ready, (k % 2 == 0));
      if (o_ready === 1'b1) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b accepts", acc, 4);
    @(negedge clk);

    sel = 2'd2;
    xfer(1'b1, 32'h30, 32'h1111_1111, 4'hF, 4, "l4st", r, e);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("mid wait stall", o_stall, 1'b1);
    rst[2] = 1'b1;
    @(negedge clk);
    #1;
    chk("mid rst ready", o_ready, 1'b1);
    chk("mid rst stall", o_stall, 1'b0);
    chk("mid rst out", {o_rv, o_err, o_rdata}, 34'h0);
    rst[2] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_rv === 1'b1) cnt++;
    end
    chk("mid rst no rsp", cnt, 0);

    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h2222_2222;
    req_be = 4'hF; req_valid = 1'b1; rst[2] = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst[2] = 1'b0;
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 4, "l4ld", r, e);
    chk("rst acc nowrite", r, 32'h1111_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder for the MIPS pipeline data path: the memory-side end of the load/store interface.
- The data path supplies address (ALU result), store data (register-file read port 2) and byte enables. This block answers with load data and a stall.
- One request is outstanding at a time, with a fixed, parameterised access latency, so pipeline stalling on memory can be exercised.
- Sits between the pipeline MEM stage and a word-organised RAM array.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two; addresses 0 .. 4*DEPTH_WORDS-1 are valid.
- LATENCY, 2: edges from request accept to response cycle; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  MEM stage presents a load/store this cycle
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i = byte lane i, little-endian
- rsp_valid  out  1  response cycle; rsp_rdata and rsp_err are meaningful
- rsp_rdata  out  32  load data (0 for stores and errors)
- rsp_err  out  1  misaligned or out-of-range access
- stall  out  1  freeze the pipeline
- mmio_q  out  32  memory-mapped output register (see Optional Feature)

Behaviour:
- Reset values:
  - State IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; stall=0; mmio_q=0; latency counter 0.
  - The RAM array is not reset.
- States:
  - IDLE: req_ready=1. On req_valid, the request is accepted at the edge and its fields are latched internally.
    - LATENCY=1 -> go to RESP.
    - Otherwise -> load counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready=0. Counter decrements each edge. At counter==1 -> RESP.
  - RESP: exactly one cycle. rsp_valid=1, req_ready=0; unconditionally -> IDLE.
- Handshake and throughput:
  - Accept = req_valid & req_ready.
  - Maximum throughput is one request per LATENCY+1 cycles, because of the RESP bubble.
  - Latched fields are used from the accept edge onward; input changes after accept are ignored.
- stall:
  - stall = (IDLE & req_valid) | WAIT.
  - stall is 0 in RESP, so the pipeline advances in the response cycle and captures rsp_rdata.
- Error checks:
  - Misaligned: addr[1:0] != 0 -> rsp_err=1, no write, rsp_rdata=0.
  - Out of range: addr >= 4*DEPTH_WORDS and not the MMIO address -> rsp_err=1, no write, rsp_rdata=0.
  - rsp_err is valid only in RESP; it is 0 at all other times.
- Stores:
  - The RAM write happens at the accept edge. Only lanes with req_be set are written.
  - req_be=0 is a legal no-op that still gets a response.
  - Response: rsp_valid=1, rsp_rdata=0.
- Loads:
  - The word is read at word index addr[log2(4*DEPTH_WORDS)-1:2]. It is registered into rsp_rdata on the edge entering RESP.
  - req_be is ignored for loads; the full word is returned.
- Outputs outside RESP: rsp_rdata holds 0.
- Reset with a request in progress: the state returns to IDLE and any pending response is dropped (no rsp_valid).
  - If reset coincides with an accept edge, no RAM write occurs.
  - A store already written before reset stays written.
- No back-to-back hazard is possible: a request is only accepted in IDLE.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Word address 0xFFFF_FFF0 maps to mmio_q.
  - Stores update mmio_q per req_be at the accept edge.
  - Loads return mmio_q. rsp_err=0 for this address.
- Undefined:
  - mmio_q is tied to 0.
  - 0xFFFF_FFF0 is treated as out of range (rsp_err=1).

Decomposition:
- Package dmem_pkg contains:
  - state enumeration {IDLE, WAIT, RESP}, 2 bits;
  - constant MMIO_ADDR = 32'hFFFF_FFF0;
  - constant LAT_W = 4 (counter width).
- Sub-module dmem_array: byte-enabled, synchronous-write, combinational-read word RAM (parameter DEPTH_WORDS).
  - The FSM, error checks and MMIO register stay in dmem_resp.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF -> stall high 2 cycles, rsp_valid in cycle 3, rdata=0, err=0.
  - Then load 0x10 -> rsp_rdata=0xDEADBEEF on the third cycle after accept.
- Byte-lane store:
  - Preload 0x20=0x11223344; store be=4'b0101, wdata=0xAABBCCDD.
  - A subsequent load returns 0x11BB33DD.
- Errors:
  - Load addr=0x13 -> rsp_err=1, rdata=0.
  - Store addr=4*DEPTH_WORDS (0x400) -> rsp_err=1, and word 0 is unchanged afterwards.
- LATENCY=1, back-to-back:
  - req_valid held high for 4 loads -> accepts occur every 2nd cycle.
  - rsp_valid pattern 0,1,0,1,...; req_ready low in RESP.
- Reset mid-operation:
  - LATENCY=4; assert reset in WAIT -> no rsp_valid ever for that request.
  - The next cycle shows req_ready=1, stall=0, and the IDLE defaults.
- MMIO (DMEM_MMIO_EN defined):
  - Store 0xFFFF_FFF0, be=4'h3, wdata=0x12345678 -> mmio_q=0x00005678.
  - Load returns 0x00005678.
  - With the macro undefined, the same store gives rsp_err=1 and mmio_q stays 0.
